// File: rtl/msdap_control_mc_if.sv
// Control bundle between the MSDAP sequencer and its datapath.
// master = controller side, slave = datapath side.
interface msdap_control_mc_if #(
  parameter int NUM_CH      = 2,
  parameter int RJ_WORDS    = 16,
  parameter int COEFF_WORDS = 512,
  parameter int DATA_DEPTH  = 256
);
  localparam int RJ_AW = $clog2(NUM_CH * RJ_WORDS);
  localparam int CF_AW = $clog2(NUM_CH * COEFF_WORDS);
  localparam int DA_AW = $clog2(DATA_DEPTH);

  logic              start;
  logic              frame;
  logic              word_valid;
  logic [NUM_CH-1:0] word_zero;
  logic              clear_req;
  logic [NUM_CH-1:0] conv_done;
  logic [3:0]        state;
  logic              in_ready;
  logic              rj_wr_en;
  logic              coeff_wr_en;
  logic              data_wr_en;
  logic [RJ_AW-1:0]  rj_addr;
  logic [CF_AW-1:0]  coeff_addr;
  logic [DA_AW-1:0]  data_addr;
  logic              mem_clear;
  logic [DA_AW-1:0]  clear_addr;
  logic              alu_start;
  logic [NUM_CH-1:0] out_load;
  logic              sleep;

  modport master (
    input  start, frame, word_valid, word_zero,
    input  clear_req, conv_done,
    output state, in_ready,
    output rj_wr_en, coeff_wr_en, data_wr_en,
    output rj_addr, coeff_addr, data_addr,
    output mem_clear, clear_addr,
    output alu_start, out_load, sleep
  );

  modport slave (
    output start, frame, word_valid, word_zero,
    output clear_req, conv_done,
    input  state, in_ready,
    input  rj_wr_en, coeff_wr_en, data_wr_en,
    input  rj_addr, coeff_addr, data_addr,
    input  mem_clear, clear_addr,
    input  alu_start, out_load, sleep
  );
endinterface

// File: rtl/msdap_control_mc.sv
// MSDAP run sequencer: memory clear, Rj/coeff load,
// sample streaming with zero-run sleep and soft clear.
module msdap_control_mc #(
  parameter int NUM_CH      = 2,
  parameter int RJ_WORDS    = 16,
  parameter int COEFF_WORDS = 512,
  parameter int DATA_DEPTH  = 256,
  parameter int ZERO_RUN    = 800
) (
  input  logic clk,
  input  logic reset_n,
  msdap_control_mc_if.master bus
);

  localparam int RJ_N  = NUM_CH * RJ_WORDS;
  localparam int CF_N  = NUM_CH * COEFF_WORDS;
  localparam int RJ_AW = $clog2(RJ_N);
  localparam int CF_AW = $clog2(CF_N);
  localparam int DA_AW = $clog2(DATA_DEPTH);
  localparam int ZW    = $clog2(ZERO_RUN + 1);

  typedef enum logic [3:0] {
    INIT       = 4'd0,
    WAIT_RJ    = 4'd1,
    READ_RJ    = 4'd2,
    WAIT_COEFF = 4'd3,
    READ_COEFF = 4'd4,
    WAIT_DATA  = 4'd5,
    WORKING    = 4'd6,
    CLEARING   = 4'd7,
    SLEEPING   = 4'd8
  } st_e;

  st_e st_q, st_n;

  logic [DA_AW-1:0] clr_q, clr_n;
  logic [DA_AW-1:0] wp_q, wp_n;
  logic [DA_AW-1:0] da_addr_q, da_addr_n;
  logic [RJ_AW-1:0] rj_idx_q, rj_idx_n;
  logic [RJ_AW-1:0] rj_addr_q, rj_addr_n;
  logic [CF_AW-1:0] cf_idx_q, cf_idx_n;
  logic [CF_AW-1:0] cf_addr_q, cf_addr_n;
  logic [NUM_CH-1:0][ZW-1:0] zc_q, zc_n, zc_inc;
  logic [NUM_CH-1:0] ld_q, ld_n;
  logic swept_q, swept_n;
  logic rj_we_q, rj_we_n;
  logic cf_we_q, cf_we_n;
  logic da_we_q, da_we_n;
  logic pend_q, pend_n;
  logic alu_q, alu_n;

  logic clr_ok, wv, wake, all_run;
  logic last_clr, sweep_end;
  logic rj_last, cf_last, da_last;

  assign clr_ok = bus.clear_req &
                  ((st_q == WAIT_DATA) |
                   (st_q == WORKING) |
                   (st_q == SLEEPING));
  assign wv = bus.word_valid & ~clr_ok;

  assign last_clr  = clr_q == DA_AW'(DATA_DEPTH - 1);
  assign sweep_end = swept_q | last_clr;
  assign rj_last   = rj_idx_q == RJ_AW'(RJ_N - 1);
  assign cf_last   = cf_idx_q == CF_AW'(CF_N - 1);
  assign da_last   = wp_q == DA_AW'(DATA_DEPTH - 1);

  assign wake = (st_q == SLEEPING) & wv &
                ~(&bus.word_zero);

  always_comb begin
    zc_inc  = '0;
    all_run = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!bus.word_zero[c])
        zc_inc[c] = '0;
      else if (zc_q[c] == ZW'(ZERO_RUN))
        zc_inc[c] = zc_q[c];
      else
        zc_inc[c] = zc_q[c] + ZW'(1);
      if (zc_inc[c] != ZW'(ZERO_RUN))
        all_run = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= INIT;
    else          st_q <= st_n;
  end

  always_comb begin
    st_n = st_q;
    if (bus.start) st_n = INIT;
    else if (clr_ok) st_n = CLEARING;
    else begin
      unique case (st_q)
        INIT:
          if (last_clr) st_n = WAIT_RJ;
        WAIT_RJ:
          if (bus.frame) st_n = READ_RJ;
        READ_RJ:
          if (wv && rj_last) st_n = WAIT_COEFF;
        WAIT_COEFF:
          if (bus.frame) st_n = READ_COEFF;
        READ_COEFF:
          if (wv && cf_last) st_n = WAIT_DATA;
        WAIT_DATA:
          if (bus.frame) st_n = WORKING;
        WORKING:
          if (wv && all_run) st_n = SLEEPING;
        SLEEPING:
          if (wake) st_n = WORKING;
        CLEARING:
          if (sweep_end && !bus.clear_req)
            st_n = WAIT_DATA;
        default: st_n = INIT;
      endcase
    end
  end

  always_comb begin
    clr_n     = '0;
    swept_n   = 1'b0;
    wp_n      = wp_q;
    da_addr_n = da_addr_q;
    rj_idx_n  = rj_idx_q;
    rj_addr_n = rj_addr_q;
    cf_idx_n  = cf_idx_q;
    cf_addr_n = cf_addr_q;
    zc_n      = zc_q;
    rj_we_n   = 1'b0;
    cf_we_n   = 1'b0;
    da_we_n   = 1'b0;
    pend_n    = 1'b0;
    alu_n     = pend_q;
    ld_n      = ((st_q == WORKING) ||
                 (st_q == SLEEPING)) ?
                bus.conv_done : '0;
    if (bus.start) begin
      wp_n      = '0;
      da_addr_n = '0;
      rj_idx_n  = '0;
      rj_addr_n = '0;
      cf_idx_n  = '0;
      cf_addr_n = '0;
      zc_n      = '0;
      alu_n     = 1'b0;
      ld_n      = '0;
    end else if (clr_ok) begin
      wp_n      = '0;
      da_addr_n = '0;
      zc_n      = '0;
    end else begin
      unique case (st_q)
        INIT:
          clr_n = last_clr ? '0 : clr_q + DA_AW'(1);
        CLEARING: begin
          clr_n   = sweep_end ? '0 : clr_q + DA_AW'(1);
          swept_n = sweep_end & bus.clear_req;
        end
        READ_RJ:
          if (wv) begin
            rj_we_n   = 1'b1;
            rj_addr_n = rj_idx_q;
            rj_idx_n  = rj_last ? '0 : rj_idx_q + RJ_AW'(1);
          end
        READ_COEFF:
          if (wv) begin
            cf_we_n   = 1'b1;
            cf_addr_n = cf_idx_q;
            cf_idx_n  = cf_last ? '0 : cf_idx_q + CF_AW'(1);
          end
        WORKING:
          if (wv) begin
            da_we_n   = 1'b1;
            da_addr_n = wp_q;
            wp_n      = da_last ? '0 : wp_q + DA_AW'(1);
            zc_n      = zc_inc;
            pend_n    = ~all_run;
          end
        SLEEPING:
          if (wake) begin
            da_we_n   = 1'b1;
            da_addr_n = wp_q;
            wp_n      = da_last ? '0 : wp_q + DA_AW'(1);
            zc_n      = '0;
            pend_n    = 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_q     <= '0;
      swept_q   <= 1'b0;
      wp_q      <= '0;
      da_addr_q <= '0;
      rj_idx_q  <= '0;
      rj_addr_q <= '0;
      cf_idx_q  <= '0;
      cf_addr_q <= '0;
      zc_q      <= '0;
      rj_we_q   <= 1'b0;
      cf_we_q   <= 1'b0;
      da_we_q   <= 1'b0;
      pend_q    <= 1'b0;
      alu_q     <= 1'b0;
      ld_q      <= '0;
    end else begin
      clr_q     <= clr_n;
      swept_q   <= swept_n;
      wp_q      <= wp_n;
      da_addr_q <= da_addr_n;
      rj_idx_q  <= rj_idx_n;
      rj_addr_q <= rj_addr_n;
      cf_idx_q  <= cf_idx_n;
      cf_addr_q <= cf_addr_n;
      zc_q      <= zc_n;
      rj_we_q   <= rj_we_n;
      cf_we_q   <= cf_we_n;
      da_we_q   <= da_we_n;
      pend_q    <= pend_n;
      alu_q     <= alu_n;
      ld_q      <= ld_n;
    end
  end

  // Clear strobe is held low while reset is asserted.
  assign bus.mem_clear = reset_n &
                         ((st_q == INIT) |
                          ((st_q == CLEARING) & ~swept_q));

  assign bus.state       = st_q;
  assign bus.in_ready    = (st_q != INIT) &
                           (st_q != CLEARING);
  assign bus.sleep       = st_q == SLEEPING;
  assign bus.clear_addr  = clr_q;
  assign bus.rj_wr_en    = rj_we_q;
  assign bus.coeff_wr_en = cf_we_q;
  assign bus.data_wr_en  = da_we_q;
  assign bus.rj_addr     = rj_addr_q;
  assign bus.coeff_addr  = cf_addr_q;
  assign bus.data_addr   = da_addr_q;
  assign bus.alu_start   = alu_q;
  assign bus.out_load    = ld_q;

endmodule

// File: tb/tb_msdap_control_mc.sv
// Scoreboard bench for msdap_control_mc: driver pushes expected
// state/strobe events, negedge monitor pops and compares.
module tb_msdap_control_mc;
  localparam int NCH   = 2;
  localparam int RJW   = 4;
  localparam int CFW   = 8;
  localparam int DEPTH = 8;
  localparam int ZR    = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  msdap_control_mc_if #(
    .NUM_CH(NCH), .RJ_WORDS(RJW),
    .COEFF_WORDS(CFW), .DATA_DEPTH(DEPTH)
  ) bus ();

  msdap_control_mc #(
    .NUM_CH(NCH), .RJ_WORDS(RJW), .COEFF_WORDS(CFW),
    .DATA_DEPTH(DEPTH), .ZERO_RUN(ZR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  typedef struct {
    int cyc;
    int st;
    int rdy;
    int slp;
    int mc;
    int ca;
  } st_t;

  ev_t evq[$];
  st_t stq[$];
  int  cyc = 0;
  int  vectors = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  // reference model: sequencer position and counters
  int ms, mclr, mrj, mcf, mwp;
  int mswept;
  int mz [NCH];

  string kname [5] = '{"rj_wr", "coeff_wr", "data_wr",
                       "alu_start", "out_load"};
  bit  evx [5];
  int  eva [5];
  bit  obx [5];
  int  oba [5];
  st_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act,
                       input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    evq.push_back(e);
  endtask

  function automatic logic [1:0] rcd();
    return 2'($urandom());
  endfunction

  task automatic write_word();
    push_ev(cyc + 1, 2, mwp);
    mwp = (mwp + 1) % DEPTH;
  endtask

  task automatic drive(input bit s, input bit f, input bit v,
                       input logic [1:0] wz, input bit cr,
                       input logic [1:0] cd);
    st_t e;
    bit  allrun;
    bus.start      = s;
    bus.frame      = f;
    bus.word_valid = v;
    bus.word_zero  = wz;
    bus.clear_req  = cr;
    bus.conv_done  = cd;
    e.cyc = cyc;
    e.st  = ms;
    e.rdy = (ms != 0 && ms != 7) ? 1 : 0;
    e.slp = (ms == 8) ? 1 : 0;
    e.mc  = (ms == 0 || (ms == 7 && mswept == 0)) ? 1 : 0;
    e.ca  = mclr;
    stq.push_back(e);
    if (!s && (ms == 6 || ms == 8) && cd != 2'b00)
      push_ev(cyc + 1, 4, int'(cd));
    if (s) begin
      ms = 0; mclr = 0; mswept = 0;
      mrj = 0; mcf = 0; mwp = 0;
      foreach (mz[c]) mz[c] = 0;
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i].kind == 3 && evq[i].cyc == cyc + 1)
          evq.delete(i);
    end else if (cr && (ms == 5 || ms == 6 || ms == 8)) begin
      ms = 7; mclr = 0; mswept = 0; mwp = 0;
      foreach (mz[c]) mz[c] = 0;
    end else begin
      case (ms)
        0: if (mclr == DEPTH - 1) begin ms = 1; mclr = 0; end
           else mclr++;
        1: if (f) ms = 2;
        2: if (v) begin
             push_ev(cyc + 1, 0, mrj);
             mrj++;
             if (mrj == NCH * RJW) begin mrj = 0; ms = 3; end
           end
        3: if (f) ms = 4;
        4: if (v) begin
             push_ev(cyc + 1, 1, mcf);
             mcf++;
             if (mcf == NCH * CFW) begin mcf = 0; ms = 5; end
           end
        5: if (f) ms = 6;
        6: if (v) begin
             write_word();
             allrun = 1'b1;
             for (int c = 0; c < NCH; c++) begin
               if (wz[c]) mz[c] = (mz[c] < ZR) ? mz[c] + 1 : ZR;
               else mz[c] = 0;
               if (mz[c] != ZR) allrun = 1'b0;
             end
             if (allrun) ms = 8;
             else push_ev(cyc + 2, 3, 0);
           end
        8: if (v && wz != 2'b11) begin
             write_word();
             push_ev(cyc + 2, 3, 0);
             foreach (mz[c]) mz[c] = 0;
             ms = 6;
           end
        7: if (mswept != 0 || mclr == DEPTH - 1) begin
             mclr = 0;
             if (cr) mswept = 1;
             else begin mswept = 0; ms = 5; end
           end else mclr++;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit s, input bit f, input bit v,
                      input logic [1:0] wz, input bit cr,
                      input logic [1:0] cd);
    tick();
    drive(s, f, v, wz, cr, cd);
  endtask

  task automatic feed(input int target, input int lim);
    int n;
    n = 0;
    while (ms != target && n < lim) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom()),
           1'($urandom_range(0, 1)), rcd());
      n++;
    end
    if (ms != target) begin
      errors++;
      $display("FAIL feed_timeout: model state %0d, wanted %0d",
               ms, target);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stq.size() == 0) begin
        errors++;
        $display("FAIL state_queue: empty at cycle %0d", cyc);
      end else begin
        me = stq.pop_front();
        check("cycle_align", cyc, me.cyc);
        check("state", int'(bus.state), me.st);
        check("in_ready", int'(bus.in_ready), me.rdy);
        check("sleep", int'(bus.sleep), me.slp);
        check("mem_clear", int'(bus.mem_clear), me.mc);
        check("clear_addr", int'(bus.clear_addr), me.ca);
      end
      obx[0] = bus.rj_wr_en;    oba[0] = int'(bus.rj_addr);
      obx[1] = bus.coeff_wr_en; oba[1] = int'(bus.coeff_addr);
      obx[2] = bus.data_wr_en;  oba[2] = int'(bus.data_addr);
      obx[3] = bus.alu_start;   oba[3] = 0;
      obx[4] = |bus.out_load;   oba[4] = int'(bus.out_load);
      for (int k = 0; k < 5; k++) begin
        evx[k] = 1'b0;
        eva[k] = 0;
      end
      begin
        int i;
        i = 0;
        while (i < evq.size()) begin
          if (evq[i].cyc == cyc) begin
            evx[evq[i].kind] = 1'b1;
            eva[evq[i].kind] = evq[i].val;
            evq.delete(i);
          end else i++;
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (obx[k] || evx[k]) begin
          vectors++;
          if (obx[k] != evx[k] || (obx[k] && oba[k] != eva[k])) begin
            errors++;
            $display("FAIL %s: got en=%0b val=%0d, expected en=%0b val=%0d (cycle %0d)",
                     kname[k], obx[k], oba[k], evx[k], eva[k], cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.frame = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_zero = '0;
    bus.clear_req = 1'b0;
    bus.conv_done = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(bus.state), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_mem_clear", int'(bus.mem_clear), 0);
    check("rst_sleep", int'(bus.sleep), 0);
    check("rst_strobes", int'({bus.rj_wr_en, bus.coeff_wr_en,
                               bus.data_wr_en, bus.alu_start}), 0);
    check("rst_addrs", int'(bus.rj_addr) + int'(bus.coeff_addr) +
                       int'(bus.data_addr) + int'(bus.clear_addr), 0);
    check("rst_out_load", int'(bus.out_load), 0);

    ms = 0; mclr = 0; mswept = 0; mrj = 0; mcf = 0; mwp = 0;
    foreach (mz[c]) mz[c] = 0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    mon_en = 1'b1;

    // power-up sweep, then stray words/clears in WAIT_RJ
    feed(1, 20);
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, rcd());
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());
    feed(3, 100);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());
    feed(5, 200);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());

    // nonzero stream with wrap and random gaps
    for (int w = 0; w < 10; w++) begin
      step(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 2)), 1'b0, rcd());
      if ($urandom_range(0, 1) == 1)
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    end

    // zero run into sleep, discarded zero word, then wake
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, rcd());
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, rcd());
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, rcd());
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());

    // random streaming biased towards zero samples
    repeat (60)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b11,
           1'b0, rcd());
    if (ms == 8) step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, rcd());

    // soft clear held 12 cycles, first with a coincident word
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, rcd());
    repeat (11)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'b00, 1'b1, rcd());
    n = 0;
    while (ms != 5 && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
      n++;
    end
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    @(negedge clk);
    check("clear_exit_data_addr", int'(bus.data_addr), 0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());
    repeat (4) step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, rcd());
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());

    // restart, reload, then start again mid coefficient load
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    feed(1, 20);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());
    feed(3, 100);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, rcd());
    n = 0;
    while (mcf < 6 && n < 20) begin
      step(1'b0, 1'b0, 1'b1, 2'($urandom()), 1'b0, rcd());
      n++;
    end
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    @(negedge clk);
    check("pre_start_coeff_addr", int'(bus.coeff_addr), 5);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    @(negedge clk);
    check("start_coeff_addr", int'(bus.coeff_addr), 0);
    check("start_rj_addr", int'(bus.rj_addr), 0);
    check("start_data_addr", int'(bus.data_addr), 0);
    feed(1, 20);
    repeat (4) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, rcd());
    @(negedge clk);
    #1 mon_en = 1'b0;

    if (stq.size() != 0 || evq.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d state and %0d strobe events unmatched",
               stq.size(), evq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule

// File: doc/msdap_control_mc.md
Name: msdap_control_mc

Overview:
- Multi-channel, parametrised sequencing controller for the MSDAP datapath.
- Owns the whole run sequence: power-up data-memory clear, Rj load, coefficient load, sample streaming, soft clear, and zero-run sleep/wake.
- Has internal word counters and address generators, so the datapath needs no separate done flags.
- Sits between the serial-to-parallel input stage and the Rj/coeff/data memories, ALU and parallel-to-serial output stage.

Parameters:
- NUM_CH, 2, number of audio channels; each word_valid delivers one word per channel.
- RJ_WORDS, 16, Rj words per channel.
- COEFF_WORDS, 512, coefficient words per channel.
- DATA_DEPTH, 256, data-memory depth per channel (circular buffer).
- ZERO_RUN, 800, consecutive all-zero samples per channel required before sleep.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous restart pulse; forces INIT from any state.
- frame  in  1  frame marker from the input stage; arms the load/work phases.
- word_valid  in  1  one-cycle pulse: a parallel word set is available.
- word_zero  in  NUM_CH  per-channel flag: the current sample is zero; sampled with word_valid.
- clear_req  in  1  synchronous soft-clear request, active high.
- conv_done  in  NUM_CH  per-channel ALU convolution complete pulse.
- state  out  4  current state encoding.
- in_ready  out  1  controller accepts input words.
- rj_wr_en, coeff_wr_en, data_wr_en  out  1 each  memory write strobes.
- rj_addr  out  clog2(NUM_CH*RJ_WORDS)  Rj write address.
- coeff_addr  out  clog2(NUM_CH*COEFF_WORDS)  coefficient write address.
- data_addr  out  clog2(DATA_DEPTH)  data write pointer.
- mem_clear  out  1  data-memory clear strobe.
- clear_addr  out  clog2(DATA_DEPTH)  address being cleared.
- alu_start  out  1  one-cycle ALU start pulse.
- out_load  out  NUM_CH  p2s load pulse, conv_done delayed by 1 cycle.
- sleep  out  1  high in SLEEPING.

Behaviour:
- State encoding: INIT=0, WAIT_RJ=1, READ_RJ=2, WAIT_COEFF=3, READ_COEFF=4, WAIT_DATA=5, WORKING=6, CLEARING=7, SLEEPING=8.
- Reset (reset_n low, async):
  - state=INIT.
  - All outputs, addresses, counters and zero-run counters = 0.
- Priority, highest first: reset_n, start, clear_req, word_valid.
- start high in any state -> INIT on the next edge; all counters are zeroed.
- INIT:
  - mem_clear=1; clear_addr sweeps 0..DATA_DEPTH-1, one per cycle.
  - The edge after clear_addr=DATA_DEPTH-1 -> WAIT_RJ (DATA_DEPTH cycles in INIT).
- WAIT_RJ / WAIT_COEFF / WAIT_DATA:
  - in_ready=1.
  - word_valid is ignored.
  - frame -> READ_RJ / READ_COEFF / WORKING respectively.
- READ_RJ:
  - Each word_valid at cycle n -> rj_wr_en=1 at n+1 with rj_addr = word index; the index increments after each write.
  - After write NUM_CH*RJ_WORDS-1 -> WAIT_COEFF, on the same edge that registers that strobe.
- READ_COEFF: same scheme with coeff_wr_en/coeff_addr and NUM_CH*COEFF_WORDS words -> WAIT_DATA.
- WORKING:
  - word_valid at n -> data_wr_en=1 at n+1 with data_addr; alu_start at n+2.
  - data_addr increments after each write and wraps DATA_DEPTH-1 -> 0.
  - Per-channel zero counter: increments, saturating at ZERO_RUN, when word_zero[c]=1 with word_valid; clears to 0 when word_zero[c]=0.
  - When every counter reaches ZERO_RUN -> SLEEPING on that same edge. That word is still written, but its alu_start is suppressed.
- SLEEPING:
  - sleep=1, in_ready=1.
  - All-zero words are discarded: no write, no alu_start, data_addr unchanged.
  - word_valid with any word_zero bit 0: the word is written normally, alu_start is issued, all zero counters are cleared, -> WORKING.
- clear_req in WAIT_DATA, WORKING or SLEEPING -> CLEARING. It is ignored in all other states.
  - A word_valid coincident with clear_req is discarded.
- CLEARING:
  - mem_clear sweep identical to INIT.
  - data_addr and zero counters are set to 0.
  - After the sweep, exit to WAIT_DATA only once clear_req is low; otherwise hold with mem_clear=0.
- out_load[c]:
  - Registered copy of conv_done[c], 1-cycle latency, in WORKING and SLEEPING; 0 elsewhere.
  - A pending conv_done still produces out_load on the edge entering SLEEPING.
- Width rule: every counter is sized with $clog2 of its terminal count. Terminal detection uses equality, never overflow.

Test Plan:
Use NUM_CH=2, RJ_WORDS=4, COEFF_WORDS=8, DATA_DEPTH=8, ZERO_RUN=3.
1. Release reset -> INIT for exactly 8 cycles; clear_addr 0..7 with mem_clear=1; then state=1 with in_ready=1.
2. frame, then 8 word_valid pulses -> rj_wr_en pulses at rj_addr 0..7; state=3 on the edge of the 8th strobe. Repeat with 16 words -> coeff_addr 0..15, then state=5.
3. frame, then 10 nonzero words -> data_addr 0..7,0,1 (wrap); alu_start exactly 1 cycle after each data_wr_en.
4. In WORKING: word_zero=2'b11 three times -> state=8, sleep=1. Next zero word: no data_wr_en. Then word_zero=2'b01 -> write + alu_start, state=6.
5. clear_req held 12 cycles during WORKING with a coincident word_valid -> no write for that word; 8-cycle mem_clear sweep; stays in 7 until clear_req drops; data_addr=0 at exit to state=5.
6. start pulse mid-READ_COEFF at coeff_addr=5 -> state=0 next edge; addresses zeroed; full INIT sweep repeats.
